// File: rtl/wb_sram_responder_if.sv
// Wishbone classic bus bundle between a master and the byte-lane SRAM responder.
// Signal names keep the slave-side _i/_o suffixes so both ends read like the bus datasheet.
interface wb_sram_responder_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [XLEN/8-1:0]     sel_i;
    logic [XLEN-1:0]       dat_i;
    logic [XLEN-1:0]       dat_o;
    logic                  ack_o;
    logic                  err_o;

    modport slave (
        input  cyc_i,
        input  stb_i,
        input  we_i,
        input  adr_i,
        input  sel_i,
        input  dat_i,
        output dat_o,
        output ack_o,
        output err_o
    );

    modport master (
        output cyc_i,
        output stb_i,
        output we_i,
        output adr_i,
        output sel_i,
        output dat_i,
        input  dat_o,
        input  ack_o,
        input  err_o
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone classic slave backed by a byte-lane-writable word RAM, with programmable
// wait states and error termination for malformed lane selects or out-of-range addresses.
module wb_sram_responder #(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    wb_sram_responder_if.slave      bus
);
    localparam int LANES = XLEN / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [2:0]            cnt_reg;
    logic [2:0]            cnt_next;

    logic [ADDR_WIDTH-1:0] adr_reg;
    logic                  we_reg;
    logic [LANES-1:0]      sel_reg;
    logic [XLEN-1:0]       dat_reg;
    logic                  bad_reg;

    logic                  req;
    logic                  capture;
    logic                  ack;
    logic                  err;
    logic                  ram_we;
    logic                  rd_load;

    logic [ADDR_WIDTH-1:0] cur_adr;
    logic                  cur_we;
    logic                  in_bad;
    logic                  cur_bad;
    logic                  rd_ok;
    logic [IDX_W-1:0]      ram_idx;
    logic [XLEN-1:0]       rd_q;

    function automatic logic sel_legal(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign req    = bus.cyc_i & bus.stb_i;
    assign in_bad = ~sel_legal(bus.sel_i) | ({1'b0, bus.adr_i} >= DEPTH_W);

    // With zero wait states the RAM read launches in the capture cycle, so it must
    // look at the live bus; otherwise it uses the latched request.
    always_comb begin
        cur_adr = adr_reg;
        cur_we  = we_reg;
        cur_bad = bad_reg;
        if (state_reg == IDLE) begin
            cur_adr = bus.adr_i;
            cur_we  = bus.we_i;
            cur_bad = in_bad;
        end
    end

    assign rd_ok   = ~cur_we & ~cur_bad;
    assign ram_idx = cur_adr[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            adr_reg   <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            dat_reg   <= '0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                adr_reg <= bus.adr_i;
                we_reg  <= bus.we_i;
                sel_reg <= bus.sel_i;
                dat_reg <= bus.dat_i;
                bad_reg <= in_bad;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        ack        = 1'b0;
        err        = 1'b0;
        ram_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture  = 1'b1;
                    cnt_next = 3'(WAIT_STATES);
                    state_next = (WAIT_STATES == 0) ? TERM : WAIT;
                end
            end
            WAIT: begin
                if (!bus.cyc_i) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_next = TERM;
                    end
                end
            end
            TERM: begin
                state_next = IDLE;
                // A master that drops cyc_i here abandons the transfer entirely.
                if (bus.cyc_i) begin
                    ack    = ~bad_reg;
                    err    = bad_reg;
                    ram_we = we_reg & ~bad_reg;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst_i) begin
            ack    = 1'b0;
            err    = 1'b0;
            ram_we = 1'b0;
        end
        rd_load = (state_next == TERM) && (state_reg != TERM);
    end

    // One byte-wide RAM per lane keeps the lane write enables independent.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clk_i) begin
                if (ram_we && sel_reg[gi]) begin
                    mem[ram_idx] <= dat_reg[8*gi +: 8];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lane_q <= 8'h00;
                end else if (rd_load) begin
                    lane_q <= rd_ok ? mem[ram_idx] : 8'h00;
                end
            end

            assign rd_q[8*gi +: 8] = lane_q;
        end
    endgenerate

    assign bus.dat_o = rd_q;
    assign bus.ack_o = ack;
    assign bus.err_o = err;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench for wb_sram_responder: one instance with one wait state, one with none,
// table-driven transfers checked through an expected-result queue plus abort/reset sequences.
module tb_wb_sram_responder;
    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 512;

    typedef struct {
        bit          we;
        logic [9:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst1, rst0;
    logic use_ws0;
    logic cyc, stb, we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [31:0]   dat;
    logic          ack_obs, err_obs;
    logic [31:0]   dat_obs;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    wb_sram_responder_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus1 ();
    wb_sram_responder_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus0 ();

    assign bus1.cyc_i = cyc & ~use_ws0;
    assign bus1.stb_i = stb & ~use_ws0;
    assign bus1.we_i  = we;
    assign bus1.adr_i = adr;
    assign bus1.sel_i = sel;
    assign bus1.dat_i = dat;
    assign bus0.cyc_i = cyc & use_ws0;
    assign bus0.stb_i = stb & use_ws0;
    assign bus0.we_i  = we;
    assign bus0.adr_i = adr;
    assign bus0.sel_i = sel;
    assign bus0.dat_i = dat;

    assign ack_obs = use_ws0 ? bus0.ack_o : bus1.ack_o;
    assign err_obs = use_ws0 ? bus0.err_o : bus1.err_o;
    assign dat_obs = use_ws0 ? bus0.dat_o : bus1.dat_o;

    wb_sram_responder #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1)
    );

    wb_sram_responder #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one transfer, wait for its termination and compare against the queued expectation.
    task automatic xfer(input vec_t v, input int ws);
        exp_t e;
        int   n;
        bit   done;
        e.err = v.exp_err;
        e.chk_dat = v.chk_dat;
        e.dat = v.exp_dat;
        e.lat = ws + 1;
        sb.push_back(e);
        @(negedge clk);
        we = v.we; adr = v.adr; sel = v.sel; dat = v.dat;
        cyc = 1'b1; stb = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            chk("ack_err_excl", {31'd0, ack_obs & err_obs}, 32'd0);
            if (ack_obs || err_obs) done = 1'b1;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("term_timeout", 32'(n), 32'd0);
        end else begin
            $display("xfer we=%0d adr=%0d sel=%b dat=%h -> ack=%0b err=%0b dat_o=%h lat=%0d",
                     v.we, v.adr, v.sel, v.dat, ack_obs, err_obs, dat_obs, n);
            chk("term_kind", {30'd0, ack_obs, err_obs}, {30'd0, ~e.err, e.err});
            chk("latency", 32'(n), 32'(e.lat));
            if (e.chk_dat) chk("rdata", dat_obs, e.dat);
        end
        @(posedge clk); #1;
        chk("one_cycle_pulse", {30'd0, ack_obs, err_obs}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
    endtask

    function automatic vec_t mk(input bit w, input logic [9:0] a, input logic [3:0] s,
                                input logic [31:0] d, input bit e, input bit c,
                                input logic [31:0] x);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.dat = d;
        v.exp_err = e; v.chk_dat = c; v.exp_dat = x;
        return v;
    endfunction

    initial begin
        int acks;
        int last;
        exp_t e;

        vecs[0]  = mk(1, 10'd5,   4'b1111, 32'hDEADBEEF, 0, 0, 32'h0);
        vecs[1]  = mk(0, 10'd5,   4'b1111, 32'h0,        0, 1, 32'hDEADBEEF);
        vecs[2]  = mk(1, 10'd5,   4'b0100, 32'h00AA0000, 0, 0, 32'h0);
        vecs[3]  = mk(0, 10'd5,   4'b1111, 32'h0,        0, 1, 32'hDEAABEEF);
        vecs[4]  = mk(1, 10'd5,   4'b1100, 32'h12340000, 0, 0, 32'h0);
        vecs[5]  = mk(0, 10'd5,   4'b1111, 32'h0,        0, 1, 32'h1234BEEF);
        vecs[6]  = mk(1, 10'd5,   4'b0011, 32'h00005678, 0, 0, 32'h0);
        vecs[7]  = mk(0, 10'd5,   4'b1111, 32'h0,        0, 1, 32'h12345678);
        vecs[8]  = mk(1, 10'd5,   4'b0110, 32'hFFFFFFFF, 1, 1, 32'h0);
        vecs[9]  = mk(1, 10'd5,   4'b0000, 32'hFFFFFFFF, 1, 1, 32'h0);
        vecs[10] = mk(1, 10'd512, 4'b1111, 32'hFFFFFFFF, 1, 1, 32'h0);
        vecs[11] = mk(0, 10'd5,   4'b1111, 32'h0,        0, 1, 32'h12345678);
        vecs[12] = mk(0, 10'd5,   4'b0001, 32'h0,        0, 1, 32'h12345678);
        vecs[13] = mk(0, 10'd512, 4'b1111, 32'h0,        1, 1, 32'h0);
        vecs[14] = mk(0, 10'd5,   4'b1001, 32'h0,        1, 1, 32'h0);
        vecs[15] = mk(1, 10'd7,   4'b1111, 32'h0A0B0C0D, 0, 0, 32'h0);

        rst1 = 1'b1; rst0 = 1'b1; use_ws0 = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack1", {31'd0, bus1.ack_o}, 32'd0);
        chk("reset_err1", {31'd0, bus1.err_o}, 32'd0);
        chk("reset_dat1", bus1.dat_o, 32'd0);
        chk("reset_ack0", {31'd0, bus0.ack_o}, 32'd0);
        chk("reset_dat0", bus0.dat_o, 32'd0);
        @(negedge clk);
        rst1 = 1'b0; rst0 = 1'b0;

        for (int i = 0; i < 16; i++) xfer(vecs[i], 1);

        // Abort during WAIT: no termination, write dropped.
        @(negedge clk);
        we = 1'b1; adr = 10'd7; sel = 4'b1111; dat = 32'hFFFFFFFF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("abort_wait_term", {30'd0, ack_obs, err_obs}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_wait_idle", {30'd0, ack_obs, err_obs}, 32'd0);
        end
        $display("abort in WAIT adr=7 done");
        xfer(mk(0, 10'd7, 4'b1111, 32'h0, 0, 1, 32'h0A0B0C0D), 1);

        // Abort during TERM: ack collapses with cyc_i, write dropped.
        @(negedge clk);
        we = 1'b1; adr = 10'd7; sel = 4'b1111; dat = 32'hFFFFFFFF; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("term_ack_before_drop", {31'd0, ack_obs}, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        #1;
        chk("term_ack_after_drop", {30'd0, ack_obs, err_obs}, 32'd0);
        @(posedge clk); #1;
        chk("term_abort_idle", {30'd0, ack_obs, err_obs}, 32'd0);
        $display("abort in TERM adr=7 done");
        xfer(mk(0, 10'd7, 4'b1111, 32'h0, 0, 1, 32'h0A0B0C0D), 1);

        // Reset landing on the TERM cycle cancels both termination and write.
        @(negedge clk);
        we = 1'b1; adr = 10'd7; sel = 4'b1111; dat = 32'h11111111; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b1;
        #1;
        chk("rst_term_ack", {31'd0, ack_obs}, 32'd0);
        chk("rst_term_err", {31'd0, err_obs}, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        chk("rst_dat_clear", dat_obs, 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        $display("reset in TERM adr=7 done");
        xfer(mk(0, 10'd7, 4'b1111, 32'h0, 0, 1, 32'h0A0B0C0D), 1);

        // Zero wait states: preload, then four back-to-back reads with stb held.
        use_ws0 = 1'b1;
        for (int i = 0; i < 4; i++)
            xfer(mk(1, 10'(i), 4'b1111, 32'hC0DE0000 + 32'(i), 0, 0, 32'h0), 0);
        for (int i = 0; i < 4; i++) begin
            e.err = 1'b0; e.chk_dat = 1'b1; e.dat = 32'hC0DE0000 + 32'(i); e.lat = 0;
            sb.push_back(e);
        end
        @(negedge clk);
        we = 1'b0; adr = 10'd0; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        last = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            chk("b2b_ack_err_excl", {31'd0, ack_obs & err_obs}, 32'd0);
            if (ack_obs) begin
                $display("b2b read cycle=%0d dat_o=%h", c, dat_obs);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("b2b_rdata", dat_obs, e.dat);
                end
                if (last >= 0) chk("b2b_spacing", 32'(c - last), 32'd2);
                last = c;
                acks++;
                if (acks < 4) adr = 10'(acks);
            end else if (acks == 4) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        chk("b2b_ack_count", 32'(acks), 32'd4);
        cyc = 1'b0; stb = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
